// File: rtl/sli_timing_gen.sv
// Video timing generator with built-in test patterns.
// Produces hsync/vsync/blank, active row/col indices, a start-of-frame
// pulse and a completed-frame counter. Every output is registered one
// cycle after the counter state it describes, so all of them stay aligned.
module sli_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  output logic [7:0]  out_red,
  output logic [7:0]  out_green,
  output logic [7:0]  out_blue,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_blank,
  output logic [9:0]  row,
  output logic [10:0] col,
  output logic        sof,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Sized copies of the timing points so every comparison is width-matched.
  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Bar edges: integer-divided width, leftover columns fall into the last bar.
  localparam logic [11:0] BAR_1 = 12'((H_ACTIVE / 4) * 1);
  localparam logic [11:0] BAR_2 = 12'((H_ACTIVE / 4) * 2);
  localparam logic [11:0] BAR_3 = 12'((H_ACTIVE / 4) * 3);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [11:0] r_hc;
  logic [10:0] r_vc;
  logic [1:0]  r_pat;

  logic        w_run;
  logic        w_eol;
  logic        w_eof;
  logic        w_origin;
  logic        w_active;
  logic        w_hs;
  logic        w_vs;
  logic [1:0]  w_pat;
  logic [7:0]  w_red;
  logic [7:0]  w_green;
  logic [7:0]  w_blue;

  // Decode the current counter position into timing qualifiers.
  always_comb begin
    // IDLE with en=1 already counts as the (0,0) cycle of a new frame.
    w_run    = (r_state == ST_RUN) || en;
    w_eol    = (r_hc == H_LAST);
    w_eof    = w_eol && (r_vc == V_LAST);
    w_origin = (r_hc == '0) && (r_vc == '0);
    w_active = w_run && (r_hc < H_ACT) && (r_vc < V_ACT);
    w_hs     = w_run && (r_hc >= HS_START) && (r_hc < HS_END);
    w_vs     = w_run && (r_vc >= VS_START) && (r_vc < VS_END);
    // The (0,0) pixel already uses the freshly sampled pattern.
    w_pat    = w_origin ? pat_sel : r_pat;
  end

  // Pattern generator; black outside the active region.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    w_red   = '0;
    w_green = '0;
    w_blue  = '0;
    if (w_active) begin
      case (w_pat)
        2'd1: begin
          w_red   = r_hc[7:0];
          w_green = r_hc[7:0];
          w_blue  = r_hc[7:0];
        end
        2'd2: begin
          w_red   = r_vc[7:0];
          w_green = r_vc[7:0];
          w_blue  = r_vc[7:0];
        end
        2'd3: begin
          if (r_hc < BAR_1) begin
            w_red   = 8'hFF;
            w_green = 8'hFF;
            w_blue  = 8'hFF;
          end else if (r_hc < BAR_2) begin
            w_red   = 8'hFF;
          end else if (r_hc < BAR_3) begin
            w_green = 8'hFF;
          end else begin
            w_blue  = 8'hFF;
          end
        end
        default: ;
      endcase
    end
  end

  // Run/idle state, raster counters, latched pattern and frame counter.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rstn) begin
      r_state   <= ST_IDLE;
      r_hc      <= '0;
      r_vc      <= '0;
      r_pat     <= '0;
      frame_cnt <= '0;
    end else if (w_run) begin
      r_pat <= w_pat;
      if (w_eol) begin
        r_hc <= '0;
        r_vc <= w_eof ? 11'd0 : r_vc + 11'd1;
      end else begin
        r_hc <= r_hc + 12'd1;
      end
      // en only matters at the frame boundary; mid-frame frames always complete.
      r_state <= (w_eof && !en) ? ST_IDLE : ST_RUN;
      if (w_eof) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Register all pixel and timing outputs from the current counter state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_red   <= '0;
      out_green <= '0;
      out_blue  <= '0;
      out_hsync <= ~HS_POL;
      out_vsync <= ~VS_POL;
      out_blank <= 1'b1;
      row       <= '0;
      col       <= '0;
      sof       <= 1'b0;
    end else begin
      out_red   <= w_red;
      out_green <= w_green;
      out_blue  <= w_blue;
      out_hsync <= w_hs ? HS_POL : ~HS_POL;
      out_vsync <= w_vs ? VS_POL : ~VS_POL;
      out_blank <= ~w_active;
      row       <= w_active ? r_vc[9:0]  : 10'd0;
      col       <= w_active ? r_hc[10:0] : 11'd0;
      sof       <= w_active && w_origin;
    end
  end

endmodule

// File: tb/tb_sli_timing_gen.sv
// Self-checking bench for sli_timing_gen with a tiny 8x6 raster
// (H 4/1/2/1, V 3/1/1/1). A reference model predicts each cycle's
// outputs into a queue; the entry is popped and compared after the edge.
module tb_sli_timing_gen;

  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FT = HT * VT;

  typedef struct packed {
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
    logic        hs;
    logic        vs;
    logic        blank;
    logic [9:0]  row;
    logic [10:0] col;
    logic        sof;
    logic [7:0]  fc;
  } out_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic [1:0]  pat_sel;
  logic [7:0]  out_red, out_green, out_blue;
  logic        out_hsync, out_vsync, out_blank;
  logic [9:0]  row;
  logic [10:0] col;
  logic        sof;
  logic [7:0]  frame_cnt;

  sli_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .en(en), .pat_sel(pat_sel),
    .out_red(out_red), .out_green(out_green), .out_blue(out_blue),
    .out_hsync(out_hsync), .out_vsync(out_vsync), .out_blank(out_blank),
    .row(row), .col(col), .sof(sof), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  out_t exp_q[$];
  out_t obs;

  // Reference model state.
  bit   m_run = 0;
  int   m_pos = 0;
  int   m_fc  = 0;
  int   m_pat = 0;

  function automatic out_t idle_out(int fc);
    out_t o;
    o       = '0;
    o.blank = 1'b1;
    o.fc    = 8'(fc);
    return o;
  endfunction

  // One clock: predict, push, clock, pop, compare the full output bundle.
  task automatic step(input string name);
    out_t e;
    out_t a;
    int   hc, vc, p;
    if (!rstn) begin
      e = idle_out(0);
      m_run = 0; m_pos = 0; m_fc = 0; m_pat = 0;
    end else if (!(m_run || en)) begin
      e = idle_out(m_fc);
    end else begin
      hc = m_pos % HT;
      vc = m_pos / HT;
      p  = (m_pos == 0) ? int'(pat_sel) : m_pat;
      m_pat = p;
      e = '0;
      e.blank = !(hc < 4 && vc < 3);
      e.hs    = (hc == 5 || hc == 6);
      e.vs    = (vc == 4);
      if (!e.blank) begin
        e.row = 10'(vc);
        e.col = 11'(hc);
        e.sof = (m_pos == 0);
        case (p)
          1: begin e.r = 8'(hc); e.g = 8'(hc); e.b = 8'(hc); end
          2: begin e.r = 8'(vc); e.g = 8'(vc); e.b = 8'(vc); end
          3: case (hc)
               0: begin e.r = 8'hFF; e.g = 8'hFF; e.b = 8'hFF; end
               1: e.r = 8'hFF;
               2: e.g = 8'hFF;
               default: e.b = 8'hFF;
             endcase
          default: ;
        endcase
      end
      if (m_pos == FT - 1) begin
        m_fc  = (m_fc + 1) % 256;
        m_run = en;
      end else begin
        m_run = 1;
      end
      m_pos = (m_pos + 1) % FT;
      e.fc  = 8'(m_fc);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    a.r = out_red; a.g = out_green; a.b = out_blue;
    a.hs = out_hsync; a.vs = out_vsync; a.blank = out_blank;
    a.row = row; a.col = col; a.sof = sof; a.fc = frame_cnt;
    obs = a;
    e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s t=%0t got %h exp %h", name, $time, a, e);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; pat_sel = 2'd0;
    repeat (3) step("reset");
    checks++;
    if (obs.blank !== 1'b1 || obs.fc !== 8'd0 || obs.hs !== 1'b0 || obs.sof !== 1'b0) begin
      errors++;
      $display("FAIL reset_values got blank=%b fc=%0d hs=%b sof=%b exp 1 0 0 0",
               obs.blank, obs.fc, obs.hs, obs.sof);
    end
  endtask

  task automatic test_first_frame();
    logic [31:0] rgb4;
    logic [7:0]  hs_mask;
    int          sof_n;
    rgb4 = '0; hs_mask = '0; sof_n = 0;
    rstn = 1'b1; en = 1'b1; pat_sel = 2'd1;
    for (int i = 0; i < FT; i++) begin
      step("first_frame");
      if (i < 4) rgb4 = {rgb4[23:0], obs.blank ? 8'hEE : obs.r};
      if (i < 8) hs_mask[i] = obs.hs;
      if (obs.sof) sof_n += (i == 0) ? 1 : 100;
    end
    checks++;
    if (rgb4 !== 32'h00010203) begin
      errors++;
      $display("FAIL ramp_first_line got %h exp 00010203", rgb4);
    end
    checks++;
    if (hs_mask !== 8'b0110_0000) begin
      errors++;
      $display("FAIL hsync_cycles got %b exp 01100000", hs_mask);
    end
    checks++;
    if (sof_n !== 1 || obs.fc !== 8'd1) begin
      errors++;
      $display("FAIL frame1 got sof_score=%0d fc=%0d exp 1 1", sof_n, obs.fc);
    end
  endtask

  task automatic test_second_frame();
    int vs_n, sof_n;
    vs_n = 0; sof_n = 0;
    for (int i = 0; i < FT; i++) begin
      step("second_frame");
      if (obs.vs) vs_n += (i / HT == 4) ? 1 : 100;
      if (obs.sof) sof_n++;
    end
    checks++;
    if (vs_n !== 8 || sof_n !== 1 || obs.fc !== 8'd2) begin
      errors++;
      $display("FAIL frame2 got vs=%0d sof=%0d fc=%0d exp 8 1 2", vs_n, sof_n, obs.fc);
    end
  endtask

  task automatic test_en_drop();
    int act_n, bad_idle;
    act_n = 0; bad_idle = 0;
    for (int i = 0; i < FT; i++) begin
      if (i == HT) en = 1'b0;
      step("en_drop");
      if (!obs.blank) act_n++;
    end
    checks++;
    if (act_n !== 12 || obs.fc !== 8'd3) begin
      errors++;
      $display("FAIL en_drop_frame got active=%0d fc=%0d exp 12 3", act_n, obs.fc);
    end
    for (int i = 0; i < 10; i++) begin
      step("idle");
      if (obs.blank !== 1'b1 || obs.fc !== 8'd3 || obs.sof !== 1'b0) bad_idle++;
    end
    checks++;
    if (bad_idle !== 0) begin
      errors++;
      $display("FAIL idle_hold got bad_cycles=%0d exp 0", bad_idle);
    end
  endtask

  task automatic test_pat_change();
    logic [23:0] ramp_px;
    logic [23:0] bars[4];
    ramp_px = '0;
    en = 1'b1; pat_sel = 2'd1;
    for (int i = 0; i < FT; i++) begin
      if (i == HT) pat_sel = 2'd3;
      step("pat_change");
      if (i == 2 * HT + 3) ramp_px = {obs.r, obs.g, obs.b};
    end
    checks++;
    if (ramp_px !== 24'h030303) begin
      errors++;
      $display("FAIL pat_hold_midframe got %h exp 030303", ramp_px);
    end
    for (int i = 0; i < FT; i++) begin
      step("bars_frame");
      if (i < 4) bars[i] = {obs.r, obs.g, obs.b};
    end
    checks++;
    if (bars[0] !== 24'hFFFFFF || bars[1] !== 24'hFF0000 ||
        bars[2] !== 24'h00FF00 || bars[3] !== 24'h0000FF) begin
      errors++;
      $display("FAIL bars got %h %h %h %h exp FFFFFF FF0000 00FF00 0000FF",
               bars[0], bars[1], bars[2], bars[3]);
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 2 * HT + 2; i++) step("pre_reset");
    rstn = 1'b0;
    step("mid_reset");
    checks++;
    if (obs.blank !== 1'b1 || obs.fc !== 8'd0 || obs.hs !== 1'b0 ||
        obs.vs !== 1'b0 || {obs.r, obs.g, obs.b} !== 24'h0 || obs.sof !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_values got %h", obs);
    end
    rstn = 1'b1;
    step("post_reset");
    checks++;
    if (obs.sof !== 1'b1 || obs.blank !== 1'b0 || obs.col !== 11'd0 || obs.row !== 10'd0) begin
      errors++;
      $display("FAIL post_reset_sof got sof=%b blank=%b exp 1 0", obs.sof, obs.blank);
    end
  endtask

  task automatic test_fc_wrap();
    for (int i = 1; i < FT; i++) step("wrap_pre");
    for (int f = 0; f < 254; f++)
      for (int i = 0; i < FT; i++) step("wrap_run");
    checks++;
    if (obs.fc !== 8'd255) begin
      errors++;
      $display("FAIL fc_at_255 got %0d exp 255", obs.fc);
    end
    for (int i = 0; i < FT; i++) step("wrap_last");
    checks++;
    if (obs.fc !== 8'd0) begin
      errors++;
      $display("FAIL fc_wrap got %0d exp 0", obs.fc);
    end
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; pat_sel = 2'd0;
    test_reset();
    test_first_frame();
    test_second_frame();
    test_en_drop();
    test_pat_change();
    test_mid_reset();
    test_fc_wrap();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sli_timing_gen.md
SLI_TIMING_GEN -- requirements
Module: sli_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1280: active pixels per line.
REQ-002 Parameter H_FP, default 110: horizontal front porch, in pixels.
REQ-003 Parameter H_SYNC, default 40: hsync width, in pixels.
REQ-004 Parameter H_BP, default 220: horizontal back porch, in pixels.
REQ-005 Parameter V_ACTIVE, default 720: active lines per frame.
REQ-006 Parameter V_FP / V_SYNC / V_BP, defaults 5 / 5 / 20: vertical porches and sync width, in lines.
REQ-007 Parameter HS_POL / VS_POL, default 1 / 1: asserted level of hsync / vsync.
REQ-008 clk  in  1  pixel clock; all logic on rising edge.
REQ-009 rstn  in  1  synchronous, active-low reset.
REQ-010 en  in  1  run request; sampled only at frame boundary.
REQ-011 pat_sel  in  2  pattern: 0 black, 1 horizontal ramp, 2 vertical ramp, 3 four color bars.
REQ-012 out_red / out_green / out_blue  out  8 each  pixel data.
REQ-013 out_hsync / out_vsync / out_blank  out  1 each  timing outputs.
REQ-014 row  out  10  active line index, 0..V_ACTIVE-1.
REQ-015 col  out  11  active pixel index, 0..H_ACTIVE-1.
REQ-016 sof  out  1  one-cycle pulse coincident with pixel (0,0).
REQ-017 frame_cnt  out  8  completed-frame counter.

Function
REQ-018 Horizontal counter hc SHALL count 0..H_TOTAL-1 and then wrap, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. Vertical counter vc SHALL increment on the hc wrap and count 0..V_TOTAL-1, with V_TOTAL defined the same way.
REQ-019 Active region: hc<H_ACTIVE and vc<V_ACTIVE. out_blank SHALL be 0 inside the active region and 1 outside it.
REQ-020 hsync SHALL be asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), on every line, including lines in vertical blanking.
REQ-021 vsync SHALL be asserted for all hc of every line with vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
REQ-022 All outputs SHALL be registered, with 1-cycle latency from counter state. Syncs, blank, data, row, col and sof SHALL stay mutually aligned.
REQ-023 State machine states:
  - IDLE: counters held at 0; out_blank=1; syncs deasserted; RGB=0.
  - RUN: counters advance.
REQ-024 IDLE->RUN SHALL occur on the first cycle en=1. That cycle's counter state SHALL be (0,0).
REQ-025 RUN->IDLE SHALL occur only at the frame boundary (hc=H_TOTAL-1, vc=V_TOTAL-1) with en=0. Deasserting en mid-frame SHALL NOT truncate the frame.
REQ-026 pat_sel SHALL be latched at each frame start (the (0,0) cycle), so the pattern never changes mid-frame.
REQ-027 Pattern pixel values:
  - Ramp 1: R=G=B=col[7:0].
  - Ramp 2: R=G=B=row[7:0].
  - Bars: col/(H_ACTIVE/4) selects white, red, green, blue in that order. Use integer divide; any remainder columns belong to the last bar.
REQ-028 RGB SHALL be 0 whenever out_blank=1.
REQ-029 row and col SHALL hold the active indices during the active region and SHALL read 0 otherwise.
REQ-030 sof SHALL pulse for exactly one cycle per frame, aligned with the first out_blank=0 cycle.
REQ-031 frame_cnt SHALL increment by 1 at each RUN frame boundary and wrap 255->0. It SHALL hold its value in IDLE.

Reset
REQ-032 With rstn=0 at a clock edge, on the next cycle:
  - State=IDLE; hc=vc=0; frame_cnt=0.
  - out_blank=1; out_hsync=~HS_POL; out_vsync=~VS_POL; RGB=0; row=col=0; sof=0.
REQ-033 Reset mid-frame SHALL abort the frame immediately. If en=1 after reset is released, the next frame SHALL start from (0,0).

Verification (parameters: H 4/1/2/1 giving H_TOTAL=8; V 3/1/1/1 giving V_TOTAL=6; pols 1)
REQ-034 Reset release with en=1 and pat_sel=1:
  - out_blank=0 for 4 cycles with RGB 0,1,2,3.
  - sof=1 only on the first of those cycles.
  - hsync high at line cycles 5-6.
REQ-035 Run two frames: each is 48 cycles long; vsync is high for exactly 8 cycles at vc=4; frame_cnt reads 1, then 2.
REQ-036 Drop en at vc=1: the frame completes all 48 cycles, then the block enters IDLE with blank=1 and frame_cnt frozen.
REQ-037 Change pat_sel 1->3 at vc=1: the current frame stays a ramp; the next frame outputs white, red, green, blue (FFFFFF, FF0000, 00FF00, 0000FF) at col 0..3.
REQ-038 Assert rstn=0 for one cycle at vc=2, hc=2: all outputs take their reset values; with en=1, sof appears on the first cycle after release.
REQ-039 Preload frame_cnt to 255 by running 255 frames: after the next frame it reads 0.
